// File: rtl/uart_tx_scheduler_if.sv
// Request/transmit bundle between clients, the scheduler and the UART transmitter.
// master drives requests; slave is the scheduler side.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           tx_data;
    logic                 tx_transmit;
    logic                 busy;
    logic [IW-1:0]        grant_id;

    modport master (
        output req_valid,
        output req_data,
        input  req_ack,
        input  tx_data,
        input  tx_transmit,
        input  busy,
        input  grant_id
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ack,
        output tx_data,
        output tx_transmit,
        output busy,
        output grant_id
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmitter among NUM_REQ clients.
// Frame timing comes from one timer since it has no busy feedback.
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 10417,
    parameter int FRAME_BITS   = 10,
    parameter int HOLD_CLKS    = 15000,
    parameter int GAP_BITS     = 1
) (
    input logic clk,
    input logic reset,
    uart_tx_scheduler_if.slave bus
);
    localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
    localparam int GAP_CLKS   = CLKS_PER_BIT * GAP_BITS;
    localparam int BUSY_CLKS  = FRAME_CLKS + GAP_CLKS;
    localparam int TW         = $clog2(BUSY_CLKS);
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [TW-1:0] HOLD_END  = TW'(HOLD_CLKS - 1);
    localparam logic [TW-1:0] FRAME_END = TW'(FRAME_CLKS - 1);
    localparam logic [TW-1:0] BUSY_END  = TW'(BUSY_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        GAP
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [IW-1:0] ptr;

    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;

    // Pick the first valid client after the last one served, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Frame sequencer: accept, hold transmit, wait out frame and guard gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            ptr             <= IW'(NUM_REQ - 1);
            bus.req_ack     <= '0;
            bus.tx_data     <= '0;
            bus.tx_transmit <= 1'b0;
            bus.busy        <= 1'b0;
            bus.grant_id    <= '0;
        end else begin
            bus.req_ack <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        bus.tx_data     <= bus.req_data[8*int'(win) +: 8];
                        bus.grant_id    <= win;
                        ptr             <= win;
                        bus.req_ack     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                        bus.tx_transmit <= 1'b1;
                        bus.busy        <= 1'b1;
                        timer           <= '0;
                        state           <= SEND;
                    end
                end
                SEND: begin
                    timer <= timer + 1'b1;
                    if (timer == HOLD_END) begin
                        bus.tx_transmit <= 1'b0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (timer == BUSY_END) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (timer == FRAME_END) begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (timer == BUSY_END) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus random traffic,
// every cycle checked against a cycles-since-accept reference model.
module tb_uart_tx_scheduler;
    localparam int NUM_REQ = 4;
    localparam int CPB     = 4;
    localparam int FBITS   = 10;
    localparam int HOLD    = 6;
    localparam int GBITS   = 1;
    localparam int BUSY    = CPB * FBITS + CPB * GBITS;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ(NUM_REQ),
        .CLKS_PER_BIT(CPB),
        .FRAME_BITS(FBITS),
        .HOLD_CLKS(HOLD),
        .GAP_BITS(GBITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // reference model state
    bit         m_act;
    int         m_t;
    int         m_ptr;
    int         m_gid;
    logic [3:0] m_ack;
    logic [7:0] m_data;

    int cnt_tx, cnt_busy;
    int         g_id[$];
    int         g_cyc[$];
    logic [7:0] g_dat[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [3:0]  v;
        logic [31:0] d;
        bit          got;
        @(posedge clk);
        v = bus.req_valid;
        d = bus.req_data;
        if (reset) begin
            m_act = 0; m_t = 0; m_ack = '0; m_data = '0;
            m_gid = 0; m_ptr = NUM_REQ - 1;
        end else begin
            m_ack = '0;
            if (!m_act) begin
                got = 0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NUM_REQ;
                    if (!got && v[idx]) begin
                        got    = 1;
                        m_gid  = idx;
                        m_ptr  = idx;
                        m_data = d[8*idx +: 8];
                        m_ack  = 4'b0001 << idx;
                        m_act  = 1;
                        m_t    = 0;
                    end
                end
            end else begin
                m_t++;
                if (m_t == BUSY) m_act = 0;
            end
        end
        #1;
        cyc++;
        chk("req_ack", 32'(bus.req_ack), 32'(m_ack));
        chk("tx_data", 32'(bus.tx_data), 32'(m_data));
        chk("tx_transmit", 32'(bus.tx_transmit), 32'(m_act && m_t < HOLD));
        chk("busy", 32'(bus.busy), 32'(m_act));
        chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
        if (bus.tx_transmit) cnt_tx++;
        if (bus.busy) cnt_busy++;
        if (bus.req_ack != 0) begin
            g_id.push_back(int'(bus.grant_id));
            g_cyc.push_back(cyc);
            g_dat.push_back(bus.tx_data);
        end
    endtask

    task automatic clr();
        cnt_tx = 0; cnt_busy = 0;
        g_id.delete(); g_cyc.delete(); g_dat.delete();
    endtask

    initial begin
        int bad_dat;
        bus.req_valid = '0;
        bus.req_data  = '0;

        // 1: reset then a single frame from client 1
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        clr();
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_5500;
        tick();
        chk("t1_ack", 32'(bus.req_ack), 32'b0010);
        bus.req_valid = '0;
        repeat (50) tick();
        chk("t1_tx_cycles", 32'(cnt_tx), 32'(HOLD));
        chk("t1_busy_cycles", 32'(cnt_busy), 32'(BUSY));
        chk("t1_n_grants", 32'(g_id.size()), 32'd1);
        chk("t1_tx_data", 32'(bus.tx_data), 32'h55);
        chk("t1_grant", 32'(bus.grant_id), 32'd1);

        // 2: all clients held valid -> 0,1,2,3,0 spaced BUSY+1 apart
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr();
        bus.req_data  = 32'hA3A2_A1A0;
        bus.req_valid = 4'b1111;
        repeat (5 * (BUSY + 1)) tick();
        chk("t2_n_grants", 32'(g_id.size()), 32'd5);
        for (int i = 0; i < 5 && i < g_id.size(); i++) begin
            chk("t2_grant", 32'(g_id[i]), 32'(i % 4));
            chk("t2_data", 32'(g_dat[i]), 32'(8'hA0 + (i % 4)));
            if (i > 0) chk("t2_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(BUSY + 1));
        end
        bus.req_valid = '0;
        repeat (BUSY + 1) tick();

        // 3: wrap after serving client 3
        clr();
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = 4'b1001;
        repeat (2 * (BUSY + 1)) tick();
        bus.req_valid = '0;
        repeat (BUSY + 1) tick();
        chk("t3_n_grants", 32'(g_id.size()), 32'd3);
        if (g_id.size() == 3) begin
            chk("t3_g0", 32'(g_id[0]), 32'd3);
            chk("t3_g1", 32'(g_id[1]), 32'd0);
            chk("t3_g2", 32'(g_id[2]), 32'd3);
        end

        // 4: reset mid-frame at timer=20
        clr();
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        chk("t4_tx", 32'(bus.tx_transmit), 32'd0);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        chk("t4_data", 32'(bus.tx_data), 32'd0);
        reset = 1'b0;
        bus.req_valid = 4'b1100;
        tick();
        chk("t4_grant", 32'(bus.grant_id), 32'd2);
        bus.req_valid = '0;
        repeat (BUSY + 2) tick();

        // 5: valid pulse while busy is ignored
        clr();
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        repeat (10) tick();
        bus.req_valid = 4'b0010;
        repeat (5) tick();
        bus.req_valid = '0;
        repeat (BUSY) tick();
        chk("t5_n_grants", 32'(g_id.size()), 32'd1);
        chk("t5_idle", 32'(bus.busy), 32'd0);

        // 6: granted client's data toggles during the frame
        clr();
        bus.req_data  = 32'h003C_0000;
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        bad_dat = 0;
        for (int i = 0; i < BUSY; i++) begin
            bus.req_data[23:16] = bus.req_data[23:16] ^ 8'hFF;
            tick();
            if (bus.busy && bus.tx_data !== 8'h3C) bad_dat++;
        end
        chk("t6_data_stable", 32'(bad_dat), 32'd0);
        chk("t6_busy_cycles", 32'(cnt_busy), 32'(BUSY));

        // random traffic against the model
        clr();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req_valid = 4'($urandom);
            bus.req_data = $urandom;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        chk("rand_some_grants", 32'(g_id.size() > 10), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
